// File: rtl/quad_decoder_if.sv
// Encoder channel inputs and decoded pulse outputs for quad_decoder.
// The master drives the raw A/B channels; the slave (decoder) returns cw/ccw/err.
interface quad_decoder_if;
    logic a;
    logic b;
    logic cw;
    logic ccw;
    logic err;

    modport master (output a, output b, input cw, input ccw, input err);
    modport slave  (input a, input b, output cw, output ccw, output err);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, tracks the 2-bit state and emits registered pulses.
// Define QUAD_FILTER_EN to add a per-channel stability filter after the synchronizers.
module quad_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input logic           clk,
    input logic           reset_n,
    quad_decoder_if.slave bus
);

`ifdef QUAD_FILTER_EN
    localparam int unsigned PrimeLen = SYNC_STAGES + FILT_LEN - 1;
`else
    localparam int unsigned PrimeLen = SYNC_STAGES;
`endif

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  synced;
    logic [1:0]                  s;
    logic [1:0]                  prev_q;
    logic                        init_q;
    logic [4:0]                  prime_q;
    logic                        cw_d, ccw_d, err_d;
    logic                        cw_q, ccw_q, err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a, bus.b};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
    localparam logic [3:0] FiltMax = 4'(FILT_LEN);

    logic [1:0][3:0] cnt_q, cnt_d;
    logic [1:0]      cand_q;
    logic [1:0]      acc_q;

    always_comb begin
        cnt_d = cnt_q;
        s     = acc_q;
        for (int i = 0; i < 2; i++) begin
            if (synced[i] != cand_q[i]) begin
                cnt_d[i] = 4'd1;
            end else if (cnt_q[i] < FiltMax) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
            // Accept in the cycle the count completes so the filter adds only FILT_LEN-1.
            if (cnt_d[i] == FiltMax) begin
                s[i] = synced[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            cand_q <= '0;
            acc_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            cand_q <= synced;
            acc_q  <= s;
        end
    end
`else
    assign s = synced;
`endif

    always_comb begin
        cw_d  = 1'b0;
        ccw_d = 1'b0;
        err_d = 1'b0;
        if (init_q) begin
            case ({prev_q, s})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: cw_d  = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: ccw_d = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // init waits until the reset zeros have drained from the input pipeline, so a level
    // already present at release is loaded into prev instead of being decoded as motion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= 2'b00;
            init_q  <= 1'b0;
            prime_q <= '0;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q <= s;
            cw_q   <= cw_d;
            ccw_q  <= ccw_d;
            err_q  <= err_d;
            if (!init_q) begin
                if (prime_q == 5'(PrimeLen)) begin
                    init_q <= 1'b1;
                end else begin
                    prime_q <= prime_q + 5'd1;
                end
            end
        end
    end

    assign bus.cw  = cw_q;
    assign bus.ccw = ccw_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: expected pulses are queued with their due cycle at drive
// time and compared each cycle against the registered outputs.
module tb_quad_decoder;
    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef QUAD_FILTER_EN
    localparam int LAT = SYNC + FILT;
`else
    localparam int LAT = SYNC + 1;
`endif

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] CW   = 3'b100;
    localparam logic [2:0] CCW  = 3'b010;
    localparam logic [2:0] ERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        int         id;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic [2:0] obs;

    quad_decoder_if bus ();

    quad_decoder #(
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: a due entry must match exactly, otherwise the outputs must be quiet.
    always @(negedge clk) begin
        obs = {bus.cw, bus.ccw, bus.err};
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            checks++;
            assert (obs === cur.kind) else begin
                failures++;
                $error("FAIL pulse_step%0d cyc=%0d: observed=%b expected=%b (cw,ccw,err)",
                       cur.id, cyc, obs, cur.kind);
            end
        end else begin
            checks++;
            assert (obs === NONE) else begin
                failures++;
                $error("FAIL quiet cyc=%0d: observed=%b expected=%b (cw,ccw,err)",
                       cyc, obs, NONE);
            end
        end
    end

    task automatic step(input logic [1:0] ab, input logic [2:0] kind, input int hold);
        @(posedge clk);
        #1;
        {bus.a, bus.b} = ab;
        step_id++;
        if (kind != NONE) exp_q.push_back('{kind, cyc + LAT, step_id});
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic check_quiet(input int id);
        checks++;
        assert ({bus.cw, bus.ccw, bus.err} === NONE) else begin
            failures++;
            $error("FAIL direct_quiet%0d: observed=%b expected=%b (cw,ccw,err)",
                   id, {bus.cw, bus.ccw, bus.err}, NONE);
        end
    endtask

    initial begin
        // Level 11 held through reset and release must not be decoded.
        bus.a   = 1'b1;
        bus.b   = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet(1);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_quiet(2);

        // Restart from 00.
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);

        // Clockwise cycle.
        step(2'b10, CW, 10);
        step(2'b11, CW, 10);
        step(2'b01, CW, 10);
        step(2'b00, CW, 10);

        // Counter-clockwise cycle.
        step(2'b01, CCW, 10);
        step(2'b11, CCW, 10);
        step(2'b10, CCW, 10);
        step(2'b00, CCW, 10);

        // Direction reversal.
        step(2'b10, CW, 10);
        step(2'b00, CCW, 10);

        // Double transition, then resume.
        step(2'b11, ERR, 10);
        step(2'b01, CW, 10);
        step(2'b00, CW, 10);

`ifdef QUAD_FILTER_EN
        // Short low glitch on A is suppressed; a held change passes.
        step(2'b10, CW, 10);
        step(2'b00, NONE, 3);
        step(2'b10, NONE, 12);
        step(2'b00, CCW, 12);
`else
        // Changes on consecutive cycles give pulses on consecutive cycles.
        step(2'b10, CW, 1);
        step(2'b11, CW, 1);
        step(2'b01, CW, 1);
        step(2'b00, CW, 10);
`endif

        // Reset one cycle after a change drops the in-flight pulse.
        step(2'b10, NONE, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet(3);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        step(2'b11, CW, 10);
        step(2'b01, CW, 10);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL drain: observed=%0d pending expected=0 pending", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
